main_control_fsm: RTL
=====================

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 Parameter USE_MEM_READY, default 1: when 1, memory states wait for mem_ready; when 0, mem_ready is treated as constant 1.
REQ-002 clk  input  1  single clock; all state updates occur on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 mem_ready  input  1  memory handshake; access completes in a cycle where it is high.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA  output  1 each  datapath controls.
REQ-007 ALUSrcB  output  2  selects 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate<<2.
REQ-008 ALUOp  output  3  ALU control class: 000 add, 001 sub, 010 R-type, 100 and, 101 or, 111 slt, 110 bgtz.
REQ-009 PCSource  output  2  selects 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-010 BranchType  output  2  condition type: 00 beq, 01 bne, 10 bgtz.
REQ-011 illegal_op  output  1  pulse for an unrecognised opcode.
REQ-012 state_dbg  output  4  current state encoding.
REQ-013 instr_count  output  32  count of retired instructions.

Function
REQ-014 Block SHALL be a Moore FSM; outputs SHALL decode from the state register and latched opcode, except FETCH PCWrite/IRWrite, which are gated by mem_ready.
REQ-015 Every output not listed for a state SHALL be 0.
REQ-016 State encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, IMMEX=9, IMMWB=10, JUMP=11.
REQ-017 FETCH: MemRead=1, ALUSrcB=01, ALUOp=000, PCWrite=IRWrite=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
REQ-018 DECODE: ALUSrcB=11, ALUOp=000. Opcode SHALL be latched into op_q on exit from DECODE.
REQ-019 DECODE next state by opcode:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 -> EXEC
- 000100, 000101, 000111 -> BRANCH
- 001000, 001100, 001101, 001010 -> IMMEX
- 000010 -> JUMP
- any other opcode -> FETCH, with illegal_op=1 for that DECODE cycle only.
REQ-020 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=000; next state MEMRD if op_q=lw, else MEMWR.
REQ-021 MEMRD: IorD=1, MemRead=1; holds until mem_ready=1, then goes to MEMWB.
REQ-022 MEMWB: MemToReg=1, RegWrite=1; next state FETCH.
REQ-023 MEMWR: IorD=1, MemWrite=1; holds until mem_ready=1, then goes to FETCH.
REQ-024 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010; next state ALUWB.
REQ-025 ALUWB: RegDst=1, RegWrite=1; next state FETCH.
REQ-026 BRANCH: ALUSrcA=1, ALUSrcB=00, PCWriteCond=1, PCSource=01. ALUOp=110 and BranchType=10 for bgtz; ALUOp=001 for beq/bne, with BranchType=00 for beq and 01 for bne. Next state FETCH.
REQ-027 IMMEX: ALUSrcA=1, ALUSrcB=10. ALUOp=000 for addi, 100 for andi, 101 for ori, 111 for slti. Next state IMMWB.
REQ-028 IMMWB: RegDst=0, MemToReg=0, RegWrite=1; next state FETCH.
REQ-029 JUMP: PCWrite=1, PCSource=10; next state FETCH.
REQ-030 instr_count SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, IMMWB or JUMP; illegal-opcode returns SHALL NOT count; wraps from 0xFFFFFFFF to 0.
REQ-031 Instruction latency SHALL be, with mem_ready always 1: lw 5 cycles; sw, R-type and immediate ops 4 cycles; branch and jump 3 cycles. Each mem_ready=0 cycle adds one cycle.
REQ-032 A change of opcode after DECODE SHALL NOT affect outputs, because later states use op_q.

Reset
REQ-033 While reset=1: state=FETCH, op_q=0, instr_count=0, and all outputs forced to 0 (including state_dbg=0).
REQ-034 Reset asserted mid-instruction (for example in MEMWR with MemWrite=1) SHALL drop all outputs to 0 asynchronously, without waiting for a clock edge.
REQ-035 After reset deassertion, the first rising edge SHALL evaluate from FETCH.

Verification
REQ-036 Reset, then lw (100011) with mem_ready=1 -> state_dbg sequence 0,1,2,3,4,0; RegWrite=1 and MemToReg=1 only in state 4; instr_count=1.
REQ-037 R-type (000000) -> ALUOp=010 in EXEC, RegDst=1 in ALUWB; then bgtz (000111) -> ALUOp=110, BranchType=10, PCWriteCond=1; instr_count=2.
REQ-038 sw with mem_ready low for 3 cycles in MEMWR -> MemWrite held 4 cycles, then FETCH; FETCH with mem_ready=0 -> PCWrite=IRWrite=0 and state held.
REQ-039 Opcode 111111 -> illegal_op=1 for exactly 1 cycle, return to FETCH, instr_count unchanged; slti (001010) -> ALUOp=111 in IMMEX.
REQ-040 Reset pulsed during MEMRD -> all outputs 0 immediately; after release, state_dbg=0 and instr_count=0.
REQ-041 instr_count preloaded to 0xFFFFFFFF, then a jump (000010) -> PCWrite=1 and PCSource=10 in JUMP; instr_count wraps to 0.

Source files
------------

// File: rtl/main_control_fsm.sv
// Multi-cycle MIPS-style main control unit.
// A Moore FSM steps each instruction through fetch, decode and a short
// opcode-dependent tail. Datapath controls decode from the state register
// and the opcode latched at the end of DECODE. Only the FETCH PC/IR write
// strobes look at mem_ready directly. Reset forces every output low
// combinationally, so an in-flight memory write stops at once.
module main_control_fsm #(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemToReg,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic [1:0]  BranchType,
    output logic        illegal_op,
    output logic [3:0]  state_dbg,
    output logic [31:0] instr_count
);

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_IMMEX  = 4'd9,
        ST_IMMWB  = 4'd10,
        ST_JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_RTYP = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_BGTZ = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    localparam logic [1:0] BR_BEQ  = 2'b00;
    localparam logic [1:0] BR_BNE  = 2'b01;
    localparam logic [1:0] BR_BGTZ = 2'b10;

    state_e      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [31:0] count_q, count_d;
    logic        mem_rdy;
    logic        retire;

    // With the handshake disabled every memory access completes in one cycle.
    assign mem_rdy = USE_MEM_READY ? mem_ready : 1'b1;

    // Opcodes the decoder dispatches; everything else bounces back to FETCH.
    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_BGTZ,
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

    // Next state, opcode latch on DECODE exit, and retire-count increment.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d = state_q;
        op_d    = op_q;
        retire  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (mem_rdy) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                op_d = opcode;
                case (opcode)
                    OP_LW, OP_SW:                      state_d = ST_MEMADR;
                    OP_RTYPE:                          state_d = ST_EXEC;
                    OP_BEQ, OP_BNE, OP_BGTZ:           state_d = ST_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = ST_IMMEX;
                    OP_J:                              state_d = ST_JUMP;
                    default:                           state_d = ST_FETCH;
                endcase
            end
            ST_MEMADR: begin
                state_d = (op_q == OP_LW) ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                if (mem_rdy) state_d = ST_MEMWB;
            end
            ST_MEMWR: begin
                if (mem_rdy) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
            end
            ST_EXEC: begin
                state_d = ST_ALUWB;
            end
            ST_IMMEX: begin
                state_d = ST_IMMWB;
            end
            ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_IMMWB, ST_JUMP: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
        // Plain 32-bit add wraps from all-ones to zero.
        count_d = retire ? (count_q + 32'd1) : count_q;
    end

    // State register, latched opcode and retired-instruction counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            op_q    <= '0;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q <= state_d;
            op_q    <= op_d;
            count_q <= count_d;
        end
    end

    // Moore output decode; reset holds every output low without waiting for a clock.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALU_ADD;
        PCSource    = 2'b00;
        BranchType  = BR_BEQ;
        illegal_op  = 1'b0;
        state_dbg   = 4'd0;
        instr_count = 32'd0;
        if (!reset) begin
            state_dbg   = state_q;
            instr_count = count_q;
            case (state_q)
                ST_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    PCWrite = mem_rdy;
                    IRWrite = mem_rdy;
                end
                ST_DECODE: begin
                    ALUSrcB    = SRCB_IMMSH;
                    illegal_op = !is_legal(opcode);
                end
                ST_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                ST_MEMRD: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                end
                ST_MEMWB: begin
                    MemToReg = 1'b1;
                    RegWrite = 1'b1;
                end
                ST_MEMWR: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                ST_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALU_RTYP;
                end
                ST_ALUWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                ST_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    PCWriteCond = 1'b1;
                    PCSource    = PCS_ALUOUT;
                    if (op_q == OP_BGTZ) begin
                        ALUOp      = ALU_BGTZ;
                        BranchType = BR_BGTZ;
                    end else begin
                        ALUOp      = ALU_SUB;
                        BranchType = (op_q == OP_BNE) ? BR_BNE : BR_BEQ;
                    end
                end
                ST_IMMEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    case (op_q)
                        OP_ANDI: ALUOp = ALU_AND;
                        OP_ORI:  ALUOp = ALU_OR;
                        OP_SLTI: ALUOp = ALU_SLT;
                        default: ALUOp = ALU_ADD;
                    endcase
                end
                ST_IMMWB: begin
                    RegWrite = 1'b1;
                end
                ST_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = PCS_JUMP;
                end
                default: begin
                    PCWrite = 1'b0;
                end
            endcase
        end
    end

endmodule
